// File: rtl/pipelined_carry_chain_adder_if.sv
// Operand/result handshake bundle for the pipelined carry-chain adder.
// Source side drives operands and out_ready; the adder drives results.
interface pipelined_carry_chain_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Overflow;

    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, Sum, Cout, Overflow
    );

    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, Sum, Cout, Overflow
    );
endinterface

// File: rtl/pipelined_carry_chain_adder.sv
// Wide adder/subtractor resolving CHUNK bits per stage with a registered carry.
// One op per clock; the whole pipe stalls on output backpressure.
module pipelined_carry_chain_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    localparam int STAGES = WIDTH / CHUNK
) (
    input logic clk,
    input logic rst_n,
    pipelined_carry_chain_adder_if.slave bus
);
    logic             en;
    logic             xfer_in;
    logic [WIDTH-1:0] bx;
    logic             c0;

    assign en = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;
    assign xfer_in = bus.in_valid && en;
    assign bx = bus.Sub ? ~bus.B : bus.B;
    assign c0 = bus.Sub | bus.Cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand width still unresolved entering this stage; sum width leaving it.
        localparam int WI = WIDTH - k * CHUNK;
        localparam int WS = (k + 1) * CHUNK;

        logic [WI-1:0]  a_i;
        logic [WI-1:0]  b_i;
        logic           c_i;
        logic           v_i;
        logic [CHUNK:0] r;
        logic [WS-1:0]  s_n;
        logic           v_q;
        logic           c_q;
        logic [WS-1:0]  s_q;

        if (k == 0) begin : g_head
            assign a_i = bus.A;
            assign b_i = bx;
            assign c_i = c0;
            assign v_i = xfer_in;
            assign s_n = r[CHUNK-1:0];
        end else begin : g_body
            assign a_i = g_stage[k-1].g_fwd.a_q;
            assign b_i = g_stage[k-1].g_fwd.b_q;
            assign c_i = g_stage[k-1].c_q;
            assign v_i = g_stage[k-1].v_q;
            assign s_n = {r[CHUNK-1:0], g_stage[k-1].s_q};
        end

        assign r = {1'b0, a_i[CHUNK-1:0]}
                 + {1'b0, b_i[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, c_i};

        // Bubbles advance the valid bit only, so results hold while idle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_i;
                if (v_i) begin
                    c_q <= r[CHUNK];
                    s_q <= s_n;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [WI-CHUNK-1:0] a_q;
            logic [WI-CHUNK-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en && v_i) begin
                    a_q <= a_i[WI-1:CHUNK];
                    b_q <= b_i[WI-1:CHUNK];
                end
            end
        end else begin : g_tail
            logic ov_q;

            // Carry into the MSB is a^b^sum at that bit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ov_q <= 1'b0;
                end else if (en && v_i) begin
                    ov_q <= a_i[CHUNK-1] ^ b_i[CHUNK-1]
                          ^ r[CHUNK-1] ^ r[CHUNK];
                end
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].v_q;
    assign bus.Sum       = g_stage[STAGES-1].s_q;
    assign bus.Cout      = g_stage[STAGES-1].c_q;
    assign bus.Overflow  = g_stage[STAGES-1].g_tail.ov_q;
endmodule

// File: tb/tb_pipelined_carry_chain_adder.sv
// Scoreboard bench for the pipelined carry-chain adder (WIDTH=16, CHUNK=4).
// Directed latency/corner ops, backpressured stream, bubbles, mid-flight reset.
module tb_pipelined_carry_chain_adder;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_carry_chain_adder_if #(.WIDTH(W)) bus ();

    pipelined_carry_chain_adder #(
        .WIDTH(W),
        .CHUNK(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   outs_seen = 0;
    logic prev_stall = 1'b0;
    res_t held;
    logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        logic [W-1:0] bx;
        logic         c;
        logic [W:0]   t;
        res_t         r;
        bx = sub ? ~b : b;
        c = sub ? 1'b1 : cin;
        t = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, c};
        r.sum = t[W-1:0];
        r.cout = t[W];
        r.ovf = (a[W-1] == bx[W-1]) && (t[W-1] != a[W-1]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            sb.delete();
            prev_stall <= 1'b0;
        end else begin
            chk("in_ready", {31'd0, bus.in_ready},
                {31'd0, !(bus.out_valid && !bus.out_ready)});
            if (prev_stall) begin
                chk("stall_sum", {16'd0, bus.Sum}, {16'd0, held.sum});
                chk("stall_flags", {29'd0, bus.out_valid, bus.Cout, bus.Overflow},
                    {29'd0, 1'b1, held.cout, held.ovf});
            end
            prev_stall <= bus.out_valid && !bus.out_ready;
            held <= '{bus.Sum, bus.Cout, bus.Overflow};
            if (bus.out_valid && bus.out_ready) begin
                outs_seen <= outs_seen + 1;
                chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_sum", {16'd0, bus.Sum}, {16'd0, e.sum});
                    chk("sb_cout", {31'd0, bus.Cout}, {31'd0, e.cout});
                    chk("sb_ovf", {31'd0, bus.Overflow}, {31'd0, e.ovf});
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.A, bus.B, bus.Cin, bus.Sub));
        end
    end

    task automatic run_single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input logic sub, input logic [W-1:0] es,
                              input logic ec, input logic eo);
        int n;
        step();
        bus.A = a;
        bus.B = b;
        bus.Cin = cin;
        bus.Sub = sub;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 32'd3);
        chk({tag, "_sum"}, {16'd0, bus.Sum}, {16'd0, es});
        chk({tag, "_cout"}, {31'd0, bus.Cout}, {31'd0, ec});
        chk({tag, "_ovf"}, {31'd0, bus.Overflow}, {31'd0, eo});
        @(negedge clk);
        chk({tag, "_one_cycle"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        int   sent;
        int   base;
        logic acc;
        logic done;

        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Cin = 1'b0;
        bus.Sub = 1'b0;
        bus.out_ready = 1'b1;

        #12;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_sum", {16'd0, bus.Sum}, 32'd0);
        chk("rst_flags", {30'd0, bus.Cout, bus.Overflow}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        #5 rst_n = 1'b1;

        run_single("basic", 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
        run_single("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_single("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_single("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_single("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Ten back-to-back ops with a three-cycle output stall.
        base = outs_seen;
        sent = 0;
        acc = 1'b0;
        done = 1'b0;
        step();
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            bus.out_ready = !(cyc >= 6 && cyc <= 8);
            if (!bus.in_valid || acc) begin
                if (sent < 10) begin
                    bus.A = 16'($urandom);
                    bus.B = 16'($urandom);
                    bus.Cin = 1'($urandom_range(0, 1));
                    bus.Sub = 1'($urandom_range(0, 1));
                    bus.in_valid = 1'b1;
                    sent++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            #1;
            acc = bus.in_valid && bus.in_ready;
            if (sent == 10 && !bus.in_valid && sb.size() == 0)
                done = 1'b1;
            else
                step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("stream_done", {31'd0, done}, 32'd1);
        chk("stream_drained", sb.size(), 32'd0);
        chk("stream_count", outs_seen - base, 32'd10);

        repeat (5) step();
        for (int i = 0; i < 12; i++) begin
            step();
            bus.in_valid = (i < 7) ? pat[i] : 1'b0;
            bus.A = 16'($urandom);
            bus.B = 16'($urandom);
            bus.Sub = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("bubble", {31'd0, bus.out_valid},
                {31'd0, (i >= 4 && i - 4 < 7) ? pat[i-4] : 1'b0});
        end

        // Three ops in flight, then an asynchronous reset pulse.
        for (int i = 0; i < 3; i++) begin
            step();
            bus.A = 16'($urandom);
            bus.B = 16'($urandom);
            bus.in_valid = 1'b1;
        end
        step();
        bus.in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_sum", {16'd0, bus.Sum}, 32'd0);
        chk("mid_rst_flags", {30'd0, bus.Cout, bus.Overflow}, 32'd0);
        #14 rst_n = 1'b1;
        base = outs_seen;
        repeat (10) @(negedge clk);
        chk("no_stale_out", outs_seen - base, 32'd0);
        chk("post_rst_sum", {16'd0, bus.Sum}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
